// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage DLX pipeline.
// Produces the stage-latch enables and bubble controls for load-use
// hazards, taken-branch squash, data-memory wait with timeout, and debug
// halt / single-step. Also keeps a saturating count of stalled cycles.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rw,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    input  logic                   branch_taken,
    input  logic                   halt_req,
    input  logic                   step_req,
    output logic                   pc_enable,
    output logic                   if_id_enable,
    output logic                   id_ex_enable,
    output logic                   ex_mem_enable,
    output logic                   mem_wb_enable,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   halted,
    output logic                   timeout_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // wait_cnt only ever reaches MEM_TIMEOUT-1, so it needs clog2(MEM_TIMEOUT) bits
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [WAIT_W-1:0]        wait_cnt_r;
    logic [WAIT_W-1:0]        wait_cnt_nxt_s;
    logic                     timeout_err_r;
    logic                     timeout_set_s;
    logic [STALL_CNT_W-1:0]   stall_cycles_r;

    logic load_use_s;
    logic mem_stall_s;
    logic pc_en_s;
    logic if_id_en_s;
    logic id_ex_en_s;
    logic ex_mem_en_s;
    logic mem_wb_en_s;
    logic if_id_flush_s;
    logic id_ex_flush_s;

    // Hazard detection: load in EX feeding a source of the ID instruction, and memory not ready
    always_comb begin
        load_use_s  = ex_mem_read && (ex_rw != 5'd0) &&
                      ((ex_rw == id_rs) || (id_uses_rt && (ex_rw == id_rt)));
        mem_stall_s = mem_req && !mem_ready;
    end

    // Next-state and pipeline control decode; memory stall outranks branch, branch outranks load-use
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        timeout_set_s  = 1'b0;
        pc_en_s        = 1'b0;
        if_id_en_s     = 1'b0;
        id_ex_en_s     = 1'b0;
        ex_mem_en_s    = 1'b0;
        mem_wb_en_s    = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;

        case (state_r)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall_s) begin
                    // whole pipe frozen; a branch in EX stays in ID_EX and is re-evaluated later
                    state_nxt_s = ST_MEM_WAIT;
                    if (state_r == ST_RUN) begin
                        wait_cnt_nxt_s = {WAIT_W{1'b0}};
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_nxt_s    = ST_HALTED;
                        wait_cnt_nxt_s = {WAIT_W{1'b0}};
                        timeout_set_s  = 1'b1;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end else begin
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                    if (branch_taken) begin
                        // squash IF and ID; any load-use on the squashed instruction is moot
                        pc_en_s       = 1'b1;
                        if_id_en_s    = 1'b1;
                        id_ex_en_s    = 1'b1;
                        ex_mem_en_s   = 1'b1;
                        mem_wb_en_s   = 1'b1;
                        if_id_flush_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                    end else if (load_use_s) begin
                        // hold PC and IF_ID, inject a bubble into EX
                        pc_en_s       = 1'b0;
                        if_id_en_s    = 1'b0;
                        id_ex_en_s    = 1'b1;
                        ex_mem_en_s   = 1'b1;
                        mem_wb_en_s   = 1'b1;
                        if_id_flush_s = 1'b0;
                        id_ex_flush_s = 1'b1;
                    end else begin
                        pc_en_s       = 1'b1;
                        if_id_en_s    = 1'b1;
                        id_ex_en_s    = 1'b1;
                        ex_mem_en_s   = 1'b1;
                        mem_wb_en_s   = 1'b1;
                        if_id_flush_s = 1'b0;
                        id_ex_flush_s = 1'b0;
                    end
                    // the halting cycle still advances, so no handoff is lost
                    if (halt_req) begin
                        state_nxt_s = ST_HALTED;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_HALTED: begin
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
                // a step returns to RUN for one cycle; halt_req still high sends it back
                if (!halt_req) begin
                    state_nxt_s = ST_RUN;
                end else if (step_req) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            default: begin
                // unused encoding: recover to RUN with the pipe frozen for this cycle
                state_nxt_s    = ST_RUN;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end
        endcase
    end

    // State, wait counter, sticky timeout flag and saturating stall counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r        <= ST_RUN;
            wait_cnt_r     <= {WAIT_W{1'b0}};
            timeout_err_r  <= 1'b0;
            stall_cycles_r <= {STALL_CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (timeout_set_s) begin
                timeout_err_r <= 1'b1;
            end
            if ((state_r != ST_HALTED) && !pc_en_s && (stall_cycles_r != STALL_MAX)) begin
                stall_cycles_r <= stall_cycles_r + STALL_CNT_W'(1);
            end
        end
    end

    // Controls are forced inactive while reset is held
    assign pc_enable     = reset_n & pc_en_s;
    assign if_id_enable  = reset_n & if_id_en_s;
    assign id_ex_enable  = reset_n & id_ex_en_s;
    assign ex_mem_enable = reset_n & ex_mem_en_s;
    assign mem_wb_enable = reset_n & mem_wb_en_s;
    assign if_id_flush   = reset_n & if_id_flush_s;
    assign id_ex_flush   = reset_n & id_ex_flush_s;
    assign halted        = (state_r == ST_HALTED);
    assign timeout_err   = timeout_err_r;
    assign stall_cycles  = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (MEM_TIMEOUT=4,
// 4-bit stall counter so saturation is reachable). Each step pushes its
// expected controls to a queue; the entry is popped and compared mid-cycle.
module tb_pipeline_stall_ctrl;

    localparam int SCW = 4;
    // control vector order: pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush
    localparam logic [6:0] ALL = 7'b1111100;
    localparam logic [6:0] FRZ = 7'b0000000;
    localparam logic [6:0] LU  = 7'b0011101;
    localparam logic [6:0] BR  = 7'b1111111;
    localparam logic [SCW-1:0] SAT = 4'hF;

    typedef struct {
        string          tag;
        logic [6:0]     ctl;
        logic           hlt;
        logic           terr;
        logic [SCW-1:0] stall;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    logic [4:0] id_rs, id_rt, ex_rw;
    logic id_uses_rt, ex_mem_read, mem_req, mem_ready, branch_taken, halt_req, step_req;
    logic pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
    logic if_id_flush, id_ex_flush, halted, timeout_err;
    logic [SCW-1:0] stall_cycles;

    exp_t sb[$];
    logic [SCW-1:0] exp_stall;
    int tests = 0;
    int fails = 0;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(SCW)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rw(ex_rw),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .halt_req(halt_req), .step_req(step_req),
        .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
        .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .halted(halted), .timeout_err(timeout_err), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic check_out();
        exp_t e;
        logic [6:0] obs;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL scoreboard_empty obs=%0d exp>0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            obs = {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
                   if_id_flush, id_ex_flush};
            tests++;
            assert (obs === e.ctl) else begin
                fails++;
                $error("FAIL %s.ctl obs=%b exp=%b", e.tag, obs, e.ctl);
            end
            tests++;
            assert (halted === e.hlt) else begin
                fails++;
                $error("FAIL %s.halted obs=%b exp=%b", e.tag, halted, e.hlt);
            end
            tests++;
            assert (timeout_err === e.terr) else begin
                fails++;
                $error("FAIL %s.timeout_err obs=%b exp=%b", e.tag, timeout_err, e.terr);
            end
            tests++;
            assert (stall_cycles === e.stall) else begin
                fails++;
                $error("FAIL %s.stall_cycles obs=%0d exp=%0d", e.tag, stall_cycles, e.stall);
            end
        end
    endtask

    // one clock cycle with the currently driven inputs and the expected outcome
    task automatic cyc(input string tag, input logic [6:0] ectl, input logic ehlt, input logic eterr);
        exp_t e;
        e.tag = tag; e.ctl = ectl; e.hlt = ehlt; e.terr = eterr; e.stall = exp_stall;
        sb.push_back(e);
        @(negedge clock);
        check_out();
        if (!reset_n) begin
            exp_stall = '0;
        end else if (!ehlt && !ectl[6] && exp_stall != SAT) begin
            exp_stall = exp_stall + 4'd1;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rw = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        halt_req = 1'b0; step_req = 1'b0;
        exp_stall = '0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // load-use detection
        cyc("idle", ALL, 1'b0, 1'b0);
        ex_mem_read = 1'b1; ex_rw = 5'd5; id_rs = 5'd5;
        cyc("lu_rs", LU, 1'b0, 1'b0);
        id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b1;
        cyc("lu_rt", LU, 1'b0, 1'b0);
        id_uses_rt = 1'b0;
        cyc("rt_unused", ALL, 1'b0, 1'b0);
        ex_rw = 5'd0; id_rs = 5'd0;
        cyc("rw_zero", ALL, 1'b0, 1'b0);
        ex_mem_read = 1'b0; ex_rw = 5'd5; id_rs = 5'd5;
        cyc("no_load", ALL, 1'b0, 1'b0);

        // taken branch beats load-use
        ex_mem_read = 1'b1; branch_taken = 1'b1;
        cyc("br_over_lu", BR, 1'b0, 1'b0);
        ex_mem_read = 1'b0; branch_taken = 1'b0;

        // three-cycle memory wait, branch and load-use held frozen
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc("mw0", FRZ, 1'b0, 1'b0);
        branch_taken = 1'b1;
        cyc("mw1_br", FRZ, 1'b0, 1'b0);
        branch_taken = 1'b0; ex_mem_read = 1'b1;
        cyc("mw2_lu", FRZ, 1'b0, 1'b0);
        ex_mem_read = 1'b0; mem_ready = 1'b1;
        cyc("mw_done", ALL, 1'b0, 1'b0);
        mem_req = 1'b0; mem_ready = 1'b0;
        cyc("after_mw", ALL, 1'b0, 1'b0);

        // reset while in MEM_WAIT with wait_cnt=3
        mem_req = 1'b1;
        cyc("pre_rst0", FRZ, 1'b0, 1'b0);
        cyc("pre_rst1", FRZ, 1'b0, 1'b0);
        cyc("pre_rst2", FRZ, 1'b0, 1'b0);
        cyc("pre_rst3", FRZ, 1'b0, 1'b0);
        reset_n = 1'b0;
        cyc("in_rst", FRZ, 1'b0, 1'b0);
        reset_n = 1'b1; mem_req = 1'b0;
        cyc("post_rst", ALL, 1'b0, 1'b0);

        // memory timeout: five frozen cycles then halt with sticky error
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("to_frz%0d", i), FRZ, 1'b0, 1'b0);
        end
        mem_req = 1'b0; halt_req = 1'b1;
        cyc("to_halt0", FRZ, 1'b1, 1'b1);
        halt_req = 1'b0;
        cyc("to_halt1", FRZ, 1'b1, 1'b1);
        cyc("to_resume", ALL, 1'b0, 1'b1);

        // debug halt and single step from a fresh reset
        reset_n = 1'b0;
        cyc("rst2", FRZ, 1'b0, 1'b1);
        reset_n = 1'b1; halt_req = 1'b1;
        cyc("halt_adv", ALL, 1'b0, 1'b0);
        cyc("halted0", FRZ, 1'b1, 1'b0);
        step_req = 1'b1;
        cyc("step_req", FRZ, 1'b1, 1'b0);
        step_req = 1'b0;
        cyc("step_adv", ALL, 1'b0, 1'b0);
        cyc("halted1", FRZ, 1'b1, 1'b0);
        halt_req = 1'b0;
        cyc("unhalt", FRZ, 1'b1, 1'b0);
        step_req = 1'b1;
        cyc("run_step_ign", ALL, 1'b0, 1'b0);
        step_req = 1'b0;

        // stall counter saturation
        ex_mem_read = 1'b1; ex_rw = 5'd7; id_rs = 5'd7;
        for (int i = 0; i < 17; i++) begin
            cyc($sformatf("sat%0d", i), LU, 1'b0, 1'b0);
        end
        ex_mem_read = 1'b0;
        cyc("sat_hold", ALL, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
